// File: rtl/rf_link_pkg.sv
// Shared definitions for the rfin pulse-position link (transmitter and receiver).
package rf_link_pkg;
    localparam logic [7:0] RF_PREAMBLE      = 8'hFF;
    localparam int         RF_PREAMBLE_BITS = 8;
    localparam int         RF_PAYLOAD_W     = 64;
    localparam int         RF_FRAME_BITS    = RF_PREAMBLE_BITS + RF_PAYLOAD_W;

    localparam int RF_BIT_PERIOD  = 10000;
    localparam int RF_PULSE_POS   = 5000;
    localparam int RF_PULSE_WIDTH = 1;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA
    } rf_tx_state_t;
endpackage

// File: rtl/rf_bit_timer.sv
// Bit-period counter with wrap strobe and pulse-window decode of the next count value.
module rf_bit_timer #(
    parameter int BIT_PERIOD  = 10000,
    parameter int PULSE_POS   = 5000,
    parameter int PULSE_WIDTH = 1
) (
    input  logic i_PCLK,
    input  logic i_PRESETn,
    input  logic clr,
    input  logic en,
    output logic wrap,
    output logic win_nxt
);
    localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW:0] LAST   = (CW+1)'(BIT_PERIOD - 1);
    localparam logic [CW:0] WIN_LO = (CW+1)'(PULSE_POS);
    localparam logic [CW:0] WIN_HI = (CW+1)'(PULSE_POS + PULSE_WIDTH);

    if (PULSE_WIDTH < 1 || PULSE_POS + PULSE_WIDTH > BIT_PERIOD) begin : g_illegal
        $error("rf_bit_timer: pulse window does not fit in the bit period");
    end

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign wrap = en && !clr && ({1'b0, cnt} == LAST);

    always_comb begin
        cnt_nxt = cnt;
        if (clr || wrap)
            cnt_nxt = '0;
        else if (en)
            cnt_nxt = cnt + CW'(1);
    end

    // Decoding the next value lets the registered RF output line up with the count.
    assign win_nxt = ({1'b0, cnt_nxt} >= WIN_LO) && ({1'b0, cnt_nxt} < WIN_HI);

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end
endmodule

// File: rtl/rf_pulse_tx.sv
// Pulse-position frame transmitter: 8 preamble ones then a 64-bit payload, MSB first.
module rf_pulse_tx
    import rf_link_pkg::*;
#(
    parameter int BIT_PERIOD  = RF_BIT_PERIOD,
    parameter int PULSE_POS   = RF_PULSE_POS,
    parameter int PULSE_WIDTH = RF_PULSE_WIDTH
) (
    input  logic                    i_PCLK,
    input  logic                    i_PRESETn,
    input  logic                    i_start,
    input  logic [RF_PAYLOAD_W-1:0] i_data,
    input  logic                    i_abort,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_RFOUT
);
    localparam logic [6:0] LAST_BIT = 7'(RF_FRAME_BITS - 1);
    localparam logic [6:0] PRE_LAST = 7'(RF_PREAMBLE_BITS - 1);

    rf_tx_state_t             state;
    logic [RF_FRAME_BITS-1:0] sr;
    logic [6:0]               bitidx;
    logic                     wrap;
    logic                     win_nxt;
    logic                     tmr_clr;
    logic                     tmr_en;

    assign tmr_clr = (state == IDLE) || i_abort;
    assign tmr_en  = (state != IDLE);

    rf_bit_timer #(
        .BIT_PERIOD (BIT_PERIOD),
        .PULSE_POS  (PULSE_POS),
        .PULSE_WIDTH(PULSE_WIDTH)
    ) u_timer (
        .i_PCLK   (i_PCLK),
        .i_PRESETn(i_PRESETn),
        .clr      (tmr_clr),
        .en       (tmr_en),
        .wrap     (wrap),
        .win_nxt  (win_nxt)
    );

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state   <= IDLE;
            sr      <= '0;
            bitidx  <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_RFOUT <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        state   <= PRE;
                        sr      <= {RF_PREAMBLE, i_data};
                        bitidx  <= '0;
                        o_busy  <= 1'b1;
                        o_RFOUT <= RF_PREAMBLE[7] && win_nxt;
                    end else begin
                        o_RFOUT <= 1'b0;
                    end
                end
                PRE, DATA: begin
                    if (i_abort) begin
                        state   <= IDLE;
                        o_busy  <= 1'b0;
                        o_RFOUT <= 1'b0;
                    end else if (wrap) begin
                        if (bitidx == LAST_BIT) begin
                            state   <= IDLE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            o_RFOUT <= 1'b0;
                        end else begin
                            // Next bit becomes current on this edge, so decode from sr[70].
                            sr      <= sr << 1;
                            bitidx  <= bitidx + 7'd1;
                            o_RFOUT <= sr[RF_FRAME_BITS-2] && win_nxt;
                            if (bitidx == PRE_LAST)
                                state <= DATA;
                        end
                    end else begin
                        o_RFOUT <= sr[RF_FRAME_BITS-1] && win_nxt;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_busy  <= 1'b0;
                    o_RFOUT <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rf_pulse_tx.sv
// Self-checking bench for rf_pulse_tx with a cycle-offset reference model of the frame waveform.
module tb_rf_pulse_tx;
    import rf_link_pkg::*;

    localparam int BP = 20;
    localparam int PP = 10;
    localparam int PW = 2;
    localparam int NB = 72;
    localparam int FL = NB * BP;

    logic        i_PCLK = 1'b0;
    logic        i_PRESETn;
    logic        i_start;
    logic [63:0] i_data;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic        o_RFOUT;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 i_PCLK = ~i_PCLK;

    rf_pulse_tx #(
        .BIT_PERIOD (BP),
        .PULSE_POS  (PP),
        .PULSE_WIDTH(PW)
    ) dut (
        .i_PCLK   (i_PCLK),
        .i_PRESETn(i_PRESETn),
        .i_start  (i_start),
        .i_data   (i_data),
        .i_abort  (i_abort),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_RFOUT  (o_RFOUT)
    );

    typedef struct {
        logic [63:0] data;
        bit          pre;
        int          ab;
        int          xat;
        logic [63:0] xdata;
        bit          chain;
        logic [63:0] cdata;
        logic [71:0] exp_frame;
        int          exp_hi;
        int          exp_done;
    } vec_t;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: m is the number of edges after the accepting edge E0.
    function automatic logic exp_rf(input logic [71:0] f, input int m, input int ab);
        int k, p;
        if (ab >= 0 && m > ab) return 1'b0;
        if (m >= FL) return 1'b0;
        k = m / BP;
        p = m % BP;
        return f[NB-1-k] && (p >= PP) && (p < PP + PW);
    endfunction

    function automatic logic exp_busy(input int m, input int ab);
        if (ab >= 0 && m > ab) return 1'b0;
        return m < FL;
    endfunction

    function automatic logic exp_done(input int m, input int ab);
        return (ab < 0) && (m == FL);
    endfunction

    task automatic run_frame(input logic [63:0] data, input bit pre, input int ab,
                             input int xat, input logic [63:0] xdata,
                             input bit chain, input logic [63:0] cdata,
                             output logic [71:0] dec, output int hi,
                             output int done_at, output int bad);
        logic [71:0] f;
        int last;
        f = {RF_PREAMBLE, data};
        last = chain ? FL : FL + 3;
        dec = '0; hi = 0; done_at = -1; bad = 0;
        if (!pre) begin
            i_start = 1'b1;
            i_data  = data;
        end
        @(posedge i_PCLK);
        for (int m = 0; m <= last; m++) begin
            @(negedge i_PCLK);
            if (o_RFOUT !== exp_rf(f, m, ab) || o_busy !== exp_busy(m, ab) ||
                o_done !== exp_done(m, ab)) begin
                if (bad == 0)
                    $display("trace diverges at E0+%0d: rf=%b busy=%b done=%b", m, o_RFOUT, o_busy, o_done);
                bad++;
            end
            if (o_RFOUT === 1'b1) begin
                hi++;
                if (m < FL) dec[NB-1-m/BP] = 1'b1;
            end
            if (o_done === 1'b1 && done_at < 0) done_at = m;
            i_abort = (m == ab);
            if (m == xat) begin
                i_start = 1'b1;
                i_data  = xdata;
            end else if (chain && m == FL) begin
                i_start = 1'b1;
                i_data  = cdata;
            end else begin
                i_start = 1'b0;
                i_data  = {$urandom, $urandom};
            end
        end
        i_abort = 1'b0;
    endtask

    task automatic do_vec(input string tag, input vec_t v);
        logic [71:0] dec;
        int hi, done_at, bad;
        run_frame(v.data, v.pre, v.ab, v.xat, v.xdata, v.chain, v.cdata, dec, hi, done_at, bad);
        check({tag, "_trace"}, 72'(bad), 72'(0));
        check({tag, "_frame"}, dec, v.exp_frame);
        check({tag, "_hi_cycles"}, 72'(hi), 72'(v.exp_hi));
        check({tag, "_done_at"}, 72'(done_at), 72'(v.exp_done));
    endtask

    // Expected results for a random frame, evaluated from the model over the whole frame.
    task automatic model_vec(input logic [63:0] data, input int ab, output vec_t v);
        logic [71:0] f;
        f = {RF_PREAMBLE, data};
        v = '{data: data, pre: 1'b0, ab: ab, xat: -1, xdata: '0, chain: 1'b0, cdata: '0,
              exp_frame: '0, exp_hi: 0, exp_done: -1};
        for (int m = 0; m <= FL + 3; m++) begin
            if (exp_rf(f, m, ab)) begin
                v.exp_hi++;
                v.exp_frame[NB-1-m/BP] = 1'b1;
            end
            if (exp_done(m, ab) && v.exp_done < 0) v.exp_done = m;
        end
    endtask

    vec_t vecs[6];
    vec_t rv;

    initial begin
        vecs[0] = '{64'h8123456789ABCD0F, 0, -1, -1, '0, 0, '0, 72'hFF8123456789ABCD0F, 76, FL};
        vecs[1] = '{64'h0, 0, -1, -1, '0, 0, '0, 72'hFF0000000000000000, 16, FL};
        vecs[2] = '{64'h0, 0, -1, 300, '1, 1, 64'h1, 72'hFF0000000000000000, 16, FL};
        vecs[3] = '{64'h1, 1, -1, -1, '0, 0, '0, 72'hFF0000000000000001, 18, FL};
        vecs[4] = '{'1, 0, 411, -1, '0, 0, '0, 72'hFFFFF8000000000000, 42, -1};
        vecs[5] = '{'1, 0, -1, -1, '0, 0, '0, 72'hFFFFFFFFFFFFFFFFFF, 144, FL};

        i_PRESETn = 1'b0;
        i_start   = 1'b1;
        i_abort   = 1'b0;
        i_data    = {$urandom, $urandom};
        repeat (3) @(negedge i_PCLK);
        check("rst_busy", 72'(o_busy), 72'(0));
        check("rst_done", 72'(o_done), 72'(0));
        check("rst_rf", 72'(o_RFOUT), 72'(0));
        i_start   = 1'b0;
        i_PRESETn = 1'b1;
        repeat (3) @(negedge i_PCLK);
        check("idle_busy", 72'(o_busy), 72'(0));
        check("idle_rf", 72'(o_RFOUT), 72'(0));

        // Abort in IDLE must block a simultaneous start.
        i_start = 1'b1;
        i_abort = 1'b1;
        @(negedge i_PCLK);
        i_start = 1'b0;
        i_abort = 1'b0;
        check("abort_blocks_start", 72'(o_busy), 72'(0));
        repeat (2) @(negedge i_PCLK);
        check("abort_blocks_start_late", 72'(o_busy), 72'(0));

        for (int i = 0; i < 6; i++) do_vec($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 3; i++) begin
            model_vec({$urandom, $urandom}, (i == 2) ? int'($urandom_range(1, FL - 1)) : -1, rv);
            do_vec($sformatf("rnd%0d", i), rv);
        end

        // Asynchronous reset in the middle of a pulse.
        i_start = 1'b1;
        i_data  = '1;
        @(posedge i_PCLK);
        for (int m = 0; m <= 210; m++) begin
            @(negedge i_PCLK);
            i_start = 1'b0;
        end
        check("pre_rst_pulse", 72'(o_RFOUT), 72'(1));
        i_PRESETn = 1'b0;
        #1;
        check("async_rst_rf", 72'(o_RFOUT), 72'(0));
        check("async_rst_busy", 72'(o_busy), 72'(0));
        check("async_rst_done", 72'(o_done), 72'(0));
        repeat (2) @(negedge i_PCLK);
        i_PRESETn = 1'b1;
        @(negedge i_PCLK);
        check("post_rst_idle", 72'(o_busy), 72'(0));
        model_vec({$urandom, $urandom}, -1, rv);
        do_vec("after_rst", rv);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
